// File: rtl/cms_axis_trace_receiver_if.sv
// Bundle for the trace receiver: AXI-Stream beat input plus the extracted item output.
// No latency of its own; pure wiring.
// slave = receiver side, master = stream source / item consumer side.
interface cms_axis_trace_receiver_if #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = 1024
);
  logic                      S_AXIS_tvalid;
  logic                      S_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata;
  logic                      S_AXIS_tlast;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_pc;
  logic [31:0]               out_instr;
  logic                      out_last;

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    output S_AXIS_tready, out_valid, out_pc, out_instr, out_last
  );

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    input  S_AXIS_tready, out_valid, out_pc, out_instr, out_last
  );
endinterface

// File: rtl/cms_axis_trace_receiver.sv
// Trace stream terminator: extracts pc/instr/tlast from each AXI-Stream beat into an item FIFO.
// Latency: an accepted beat is visible on the item port right after the accepting edge.
// Backpressure: tready drops while the FIFO is full (independent of out_ready); optional
// tlast framing checker enabled by `CMS_RX_TLAST_CHECK_EN.
module cms_axis_trace_receiver #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = 1024,
  parameter int PC_LOCATION    = 805,
  parameter int INSTR_LOCATION = PC_LOCATION + 128,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cms_axis_trace_receiver_if.slave  bus,
  input  logic [31:0]               tlast_interval,
  input  logic                      err_clear,
  output logic [31:0]               packet_count,
  output logic                      err_tlast_early,
  output logic                      err_tlast_missing
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            last;
  } item_t;

  item_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              running_q;
  logic [31:0]       packet_count_q, packet_count_d;
  logic              push, pop;
  item_t             in_item, head;

  // Bits of the beat outside the pc/instr fields are not consumed by this block.
  logic unused_tdata;
  assign unused_tdata = ^bus.S_AXIS_tdata;

  assign bus.S_AXIS_tready = running_q && (count_q != FULL_CNT);
  assign bus.out_valid     = (count_q != '0);
  assign push              = bus.S_AXIS_tvalid && bus.S_AXIS_tready;
  assign pop               = bus.out_valid && bus.out_ready;

  assign in_item.pc    = bus.S_AXIS_tdata[PC_LOCATION +: XLEN];
  assign in_item.instr = bus.S_AXIS_tdata[INSTR_LOCATION +: 32];
  assign in_item.last  = bus.S_AXIS_tlast;

  // Head entry is read straight from storage so a beat written into an empty FIFO shows at once.
  assign head          = mem_q[rd_ptr_q];
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.out_last  = head.last;
  assign packet_count  = packet_count_q;

  // Next-state for pointers, occupancy and packet counter.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    packet_count_d = packet_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && bus.S_AXIS_tlast) packet_count_d = packet_count_q + 32'd1;
  end

  // Control state: running gate, pointers, occupancy, packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      packet_count_q <= '0;
    end else begin
      running_q      <= 1'b1;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      packet_count_q <= packet_count_d;
    end
  end

  // Item storage; cleared on reset so the item port reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_item;
    end
  end

`ifdef CMS_RX_TLAST_CHECK_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        err_early_q, err_early_d;
  logic        err_missing_q, err_missing_d;
  logic [32:0] beat_nxt;
  logic        interval_on, early_set, missing_set;

  // 33-bit compare so a saturated beat count never aliases onto the interval.
  assign beat_nxt    = {1'b0, beat_cnt_q} + 33'd1;
  assign interval_on = (tlast_interval != 32'd0);
  assign early_set   = push && bus.S_AXIS_tlast && interval_on && (beat_nxt < {1'b0, tlast_interval});
  assign missing_set = push && !bus.S_AXIS_tlast && interval_on && (beat_nxt == {1'b0, tlast_interval});

  // Framing next-state: beat count per packet and sticky error flags (set beats clear).
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (push) begin
      if (bus.S_AXIS_tlast)  beat_cnt_d = '0;
      else if (!(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + 32'd1;
    end
    err_early_d   = (err_early_q && !err_clear) || early_set;
    err_missing_d = (err_missing_q && !err_clear) || missing_set;
  end

  // Framing checker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
    end
  end

  assign err_tlast_early   = err_early_q;
  assign err_tlast_missing = err_missing_q;
`else
  // Checker not built: configuration inputs are intentionally left unconsumed.
  logic unused_cfg;
  assign unused_cfg        = ^{tlast_interval, err_clear};
  assign err_tlast_early   = 1'b0;
  assign err_tlast_missing = 1'b0;
`endif

endmodule
